i2c_target_regs: RTL
====================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h20, the 7-bit target address answered on the bus.
REQ-002 SHALL have port clk  input  1  sole clock; all logic synchronous to its rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port I2C_SCL_i  input  1  resolved bus SCL level.
REQ-005 SHALL have port I2C_SDA_i  input  1  resolved bus SDA level.
REQ-006 SHALL have ports I2C_SCL_o / I2C_SCL_t  output  1 each  tied 0 / 1; no clock stretching.
REQ-007 SHALL have ports I2C_SDA_o / I2C_SDA_t  output  1 each  SDA_o always 0; SDA_t=0 pulls low, SDA_t=1 releases.
REQ-008 SHALL have port reg_addr  output  8  current register pointer.
REQ-009 SHALL have port reg_wdata  output  8  write data, valid with reg_we.
REQ-010 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-011 SHALL have port reg_re  output  1  one-cycle read request; reg_rdata sampled on the following clk cycle.
REQ-012 SHALL have port reg_rdata  input  8  read data from user register file.
REQ-013 SHALL have port busy  output  1  high from addressed START to STOP.

Function
REQ-014 SHALL pass SCL/SDA through 2-flop synchronizers, then detect SCL rise/fall and SDA edges on synchronized values.
REQ-015 SHALL detect START as SDA fall while SCL high, STOP as SDA rise while SCL high; both take priority over bit activity.
REQ-016 SHALL sample SDA on SCL rise, MSB first; SHALL change SDA_t only on the cycle after SCL fall.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-018 START in any state -> ADDR, bit counter cleared, SDA released (repeated START supported); STOP in any state -> IDLE, SDA released, busy=0.
REQ-019 ADDR: after 8 bits, address match -> ADDR_ACK (drive ACK low one SCL period); mismatch -> IDLE until next START, no drive.
REQ-020 ADDR_ACK: R/W=0 -> PTR; R/W=1 -> assert reg_re once at ACK SCL fall, load reg_rdata next cycle, -> RD_DATA.
REQ-021 PTR: received byte loads reg_addr, ACKed, -> WR_DATA.
REQ-022 WR_DATA: each received byte pulses reg_we with reg_addr/reg_wdata for exactly one cycle at the ACK SCL rise, ACKed; reg_addr increments the next cycle.
REQ-023 RD_DATA: drive shift-register bits (SDA_t = bit); RD_ACK samples controller ACK: ACK(0) -> reg_addr+1, reg_re, reload, RD_DATA; NACK(1) -> IDLE awaiting STOP/START.
REQ-024 reg_addr SHALL wrap 8'hFF -> 8'h00 and SHALL persist across transactions (read after repeated START uses the pointer last written).
REQ-025 reg_we and reg_re SHALL never assert in the same cycle.

Reset
REQ-026 On aresetn low: state IDLE, SDA_t=1, SDA_o=0, SCL_t=1, SCL_o=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, synchronizers=1.
REQ-027 Reset mid-transaction SHALL release SDA immediately; after deassertion, the block ignores the bus until a START.

Configuration
REQ-028 Macro I2C_TARGET_GLITCH_FILTER_EN defined: SCL and SDA each pass a 3-sample filter after the synchronizer; level changes only after 3 equal consecutive samples (+3 cycles latency).
REQ-029 Macro undefined: no filter; synchronizer output used directly.

Structure
REQ-030 Package i2c_pkg SHALL hold the state enum i2c_tgt_state_t and constants I2C_ACK=1'b0, I2C_NACK=1'b1.
REQ-031 Sub-module i2c_sync_edge SHALL contain synchronizer, optional filter and rise/fall outputs; instantiated once each for SCL and SDA.

Verification (bench models controller plus bus wired-AND; clk >= 20x SCL)
REQ-032 Write 0x20+W, ptr 0x10, data 0xAB, 0xCD, STOP -> ACK on all 4 bytes; reg_we pulses (0x10,0xAB), (0x11,0xCD); busy low after STOP.
REQ-033 Write ptr 0x05, repeated START, 0x20+R, read 3 bytes with ACK,ACK,NACK, rdata=addr^0xFF -> bytes 0xFA,0xF9,0xF8; reg_re 3 pulses; SDA released after NACK.
REQ-034 Address 0x21+W -> no ACK (SDA stays high), no reg_we/reg_re, busy stays 0.
REQ-035 Ptr 0xFF, write 0x11, 0x22 -> reg_we at 0xFF then 0x00.
REQ-036 aresetn low during RD_DATA with SDA driven low -> SDA_t=1 same cycle; next valid transaction completes normally.
REQ-037 With I2C_TARGET_GLITCH_FILTER_EN: 2-cycle SCL low glitch while SCL high -> no bit sampled, no spurious START/STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register target: FSM state encoding and bus ACK levels.
// No latency or backpressure of its own.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// One I2C line: 2-flop synchronizer, optional 3-sample filter (I2C_TARGET_GLITCH_FILTER_EN, +3 clk), edge flags.
// Level latency 2 clk (5 with filter); no backpressure.
module i2c_sync_edge (
  input  logic clk,
  input  logic aresetn,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       lvl_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], din};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Level moves only once the newest sample and the two before it agree.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      if (&{hist_q, sync_q[1]})       filt_q <= 1'b1;
      else if (~|{hist_q, sync_q[1]}) filt_q <= 1'b0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) lvl_q <= 1'b1;
    else          lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target driving an 8-bit register pointer/strobe port; I2C_TARGET_GLITCH_FILTER_EN adds a line filter.
// Bus events act ~3 clk after the pins (+3 filtered); no backpressure, SCL never stretched, reg_rdata due 1 clk after reg_re.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h20
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       I2C_SCL_i,
  input  logic       I2C_SDA_i,
  output logic       I2C_SCL_o,
  output logic       I2C_SCL_t,
  output logic       I2C_SDA_o,
  output logic       I2C_SDA_t,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk), .aresetn(aresetn), .din(I2C_SCL_i),
                       .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .aresetn(aresetn), .din(I2C_SDA_i),
                       .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       ack_q, rd_load, sda_t_q;
  logic       sda_t_d, we_d, re_d, ptr_load, ptr_inc, wdata_load;
  logic       start_det, stop_det, byte_done, addr_match, rx_state;

  assign start_det  = scl_lvl & sda_fall;
  assign stop_det   = scl_lvl & sda_rise;
  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (shreg[7:1] == I2C_ADDR);
  assign rx_state   = (state_q == ADDR) || (state_q == PTR) || (state_q == WR_DATA);

  assign I2C_SCL_o = 1'b0;
  assign I2C_SCL_t = 1'b1;
  assign I2C_SDA_o = 1'b0;
  assign I2C_SDA_t = sda_t_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else if (scl_fall) begin
      case (state_q)
        ADDR:     if (byte_done) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK: state_d = shreg[0] ? RD_DATA : PTR;
        PTR:      if (byte_done) state_d = PTR_ACK;
        PTR_ACK:  state_d = WR_DATA;
        WR_DATA:  if (byte_done) state_d = WR_ACK;
        WR_ACK:   state_d = WR_DATA;
        RD_DATA:  if (byte_done) state_d = RD_ACK;
        RD_ACK:   state_d = (ack_q == I2C_NACK) ? IDLE : RD_DATA;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_t_d    = sda_t_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    ptr_load   = 1'b0;
    ptr_inc    = 1'b0;
    wdata_load = 1'b0;
    if (start_det || stop_det) begin
      sda_t_d = 1'b1;
    end else if (rd_load && state_q == RD_DATA) begin
      // The first bit of a fetched byte can only go out once reg_rdata lands.
      sda_t_d = reg_rdata[7];
    end else if (scl_fall) begin
      case (state_q)
        ADDR:     if (byte_done && addr_match) sda_t_d = I2C_ACK;
        ADDR_ACK: if (shreg[0]) re_d = 1'b1;
                  else          sda_t_d = 1'b1;
        PTR:      if (byte_done) begin
                    sda_t_d  = I2C_ACK;
                    ptr_load = 1'b1;
                  end
        PTR_ACK:  sda_t_d = 1'b1;
        WR_DATA:  if (byte_done) begin
                    sda_t_d    = I2C_ACK;
                    wdata_load = 1'b1;
                  end
        WR_ACK:   sda_t_d = 1'b1;
        RD_DATA:  sda_t_d = byte_done ? 1'b1 : shreg[6];
        RD_ACK:   if (ack_q == I2C_ACK) begin
                    re_d    = 1'b1;
                    ptr_inc = 1'b1;
                  end
        default:  sda_t_d = 1'b1;
      endcase
    end else if (scl_rise && state_q == WR_ACK) begin
      we_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sda_t_q   <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      ack_q     <= I2C_NACK;
      rd_load   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sda_t_q <= sda_t_d;
      reg_we  <= we_d;
      reg_re  <= re_d;
      rd_load <= reg_re;
      if (start_det || stop_det || (scl_fall && byte_done)) bit_cnt <= '0;
      else if (scl_rise && (rx_state || state_q == RD_DATA)) bit_cnt <= bit_cnt + 4'd1;
      if (rd_load)                               shreg <= reg_rdata;
      else if (scl_rise && rx_state)             shreg <= {shreg[6:0], sda_lvl};
      else if (scl_fall && state_q == RD_DATA)   shreg <= {shreg[6:0], 1'b0};
      if (scl_rise && state_q == RD_ACK) ack_q <= sda_lvl;
      // Writes bump the pointer the cycle after their strobe; reads bump it before the next reg_re.
      if (ptr_load)               reg_addr <= shreg;
      else if (reg_we || ptr_inc) reg_addr <= reg_addr + 8'd1;
      if (wdata_load) reg_wdata <= shreg;
      if (stop_det) busy <= 1'b0;
      else if (scl_fall && state_q == ADDR && byte_done) busy <= addr_match;
    end
  end

endmodule
